// File: rtl/ones_pattern_gen.sv
// Step-gated generator that fills a word with a requested number of contiguous 1s,
// one bit per active step, from the LSB upward or from the MSB downward.
module ones_pattern_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             command,
  input  logic [3:0]       countIn,
  input  logic             msbFirst,
  output logic [WIDTH-1:0] pattern,
  output logic [1:0]       state_reg,
  output logic             done,
  output logic             clamped
);

  // Handshake: command is a level request sampled only on step=1 edges. Raising it
  // in IDLE starts a fill with the values latched on the previous IDLE step; done
  // rises on DONE entry and stays high until command drops, after which the block
  // returns to IDLE and clears done/pattern on the next IDLE step.
  typedef enum logic [1:0] {
    ST_ILLEGAL = 2'b00,
    ST_IDLE    = 2'b01,
    ST_FILL    = 2'b10,
    ST_DONE    = 2'b11
  } state_t;

  localparam logic [4:0] WIDTH_5 = 5'(WIDTH);
  localparam logic [3:0] WIDTH_4 = 4'(WIDTH);

  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] pattern_q,   pattern_d;
  logic [3:0]       remaining_q, remaining_d;
  logic             msb_q,       msb_d;
  logic             done_q,      done_d;
  logic             clamped_q,   clamped_d;
  logic             over_width;

  assign over_width = ({1'b0, countIn} > WIDTH_5);

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    remaining_d = remaining_q;
    msb_d       = msb_q;
    done_d      = done_q;
    clamped_d   = clamped_q;
    if (step) begin
      case (state_q)
        ST_IDLE: begin
          if (command) begin
            state_d = ST_FILL;
            done_d  = 1'b0;
          end else begin
            done_d      = 1'b0;
            pattern_d   = '0;
            remaining_d = over_width ? WIDTH_4 : countIn;
            msb_d       = msbFirst;
            clamped_d   = over_width;
          end
        end
        ST_FILL: begin
          if (remaining_q == 4'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            pattern_d   = msb_q ? {1'b1, pattern_q[WIDTH-1:1]}
                                : {pattern_q[WIDTH-2:0], 1'b1};
            remaining_d = remaining_q - 4'd1;
          end
        end
        ST_DONE: begin
          done_d = 1'b1;
          if (!command) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pattern_q   <= '0;
      remaining_q <= 4'd0;
      msb_q       <= 1'b0;
      done_q      <= 1'b0;
      clamped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      remaining_q <= remaining_d;
      msb_q       <= msb_d;
      done_q      <= done_d;
      clamped_q   <= clamped_d;
    end
  end

  assign pattern   = pattern_q;
  assign state_reg = state_q;
  assign done      = done_q;
  assign clamped   = clamped_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Bench for ones_pattern_gen: directed scenarios plus randomized transactions
// checked against a count/direction model of the expected fill progress.
module tb_ones_pattern_gen;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         step;
  logic         command;
  logic [3:0]   countIn;
  logic         msbFirst;
  logic [W-1:0] pattern;
  logic [1:0]   state_reg;
  logic         done;
  logic         clamped;

  int n_checks = 0;
  int n_fail   = 0;

  ones_pattern_gen #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .command   (command),
    .countIn   (countIn),
    .msbFirst  (msbFirst),
    .pattern   (pattern),
    .state_reg (state_reg),
    .done      (done),
    .clamped   (clamped)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference: k contiguous ones at the chosen end of a W-bit word
  function automatic logic [W-1:0] ones_word(input int k, input bit msb);
    logic [31:0] m;
    m = (k == 0) ? 32'd0 : ((32'd1 << k) - 32'd1);
    if (msb) m = m << (W - k);
    return m[W-1:0];
  endfunction

  // one full request/fill/done/return cycle; gate_pct<0 means step toggles each clock
  task automatic run_txn(input int cnt, input bit msb, input int gate_pct, input bit noise);
    int  n, s, clocks;
    bit  cl;
    n = (cnt > W) ? W : cnt;
    cl = (cnt > W);
    command = 1'b0; countIn = 4'(cnt); msbFirst = msb; step = 1'b1;
    tick();
    check("idle_state",   state_reg, 2'b01);
    check("idle_done",    done, 1'b0);
    check("idle_pattern", pattern, '0);
    check("idle_clamped", clamped, cl);
    command = 1'b1;
    tick();
    check("fill_entry", state_reg, 2'b10);
    s = 0; clocks = 0;
    while (s <= n && clocks < 400) begin
      if (gate_pct < 0) step = ~step;
      else step = ($urandom_range(99) < gate_pct);
      if (noise) begin
        command  = 1'($urandom);
        countIn  = 4'($urandom);
        msbFirst = 1'($urandom);
      end
      tick();
      clocks++;
      if (step) s++;
      if (s <= n) begin
        check("fill_state",   state_reg, 2'b10);
        check("fill_pattern", pattern, ones_word(s, msb));
        check("fill_done",    done, 1'b0);
      end
    end
    if (s <= n) check("fill_timeout", 0, 1);
    if (gate_pct < 0) check("toggle_clocks", clocks, 2 * (n + 1));
    check("done_state",   state_reg, 2'b11);
    check("done_flag",    done, 1'b1);
    check("done_pattern", pattern, ones_word(n, msb));
    check("done_clamped", clamped, cl);
    command = 1'b1; step = 1'b1;
    countIn = 4'($urandom); msbFirst = 1'($urandom);
    repeat (2) tick();
    check("hold_state",   state_reg, 2'b11);
    check("hold_pattern", pattern, ones_word(n, msb));
    check("hold_clamped", clamped, cl);
    command = 1'b0;
    tick();
    check("ret_state",   state_reg, 2'b01);
    check("ret_done",    done, 1'b1);
    check("ret_pattern", pattern, ones_word(n, msb));
    tick();
    check("clr_done",    done, 1'b0);
    check("clr_pattern", pattern, '0);
  endtask

  initial begin
    reset = 1'b0; step = 1'b0; command = 1'b0; countIn = 4'd0; msbFirst = 1'b0;
    repeat (2) tick();
    check("rst_state",   state_reg, 2'b01);
    check("rst_pattern", pattern, '0);
    check("rst_done",    done, 1'b0);
    check("rst_clamped", clamped, 1'b0);
    reset = 1'b1;

    // directed scenarios
    run_txn(5,  1'b0, 100, 1'b0);
    run_txn(3,  1'b1, 100, 1'b0);
    run_txn(0,  1'b0, 100, 1'b0);
    run_txn(12, 1'b0, 100, 1'b0);
    run_txn(4,  1'b0, -1,  1'b1);
    run_txn(8,  1'b1, 100, 1'b0);
    run_txn(15, 1'b1, 100, 1'b0);

    // no advance while step is low
    command = 1'b0; countIn = 4'd6; msbFirst = 1'b0; step = 1'b1;
    tick();
    command = 1'b1; step = 1'b0;
    repeat (3) tick();
    check("stall_state", state_reg, 2'b01);

    // reset mid-FILL
    step = 1'b1;
    tick();
    repeat (3) tick();
    check("pre_rst_pattern", pattern, 8'h07);
    #2 reset = 1'b0;
    #1;
    check("async_state",   state_reg, 2'b01);
    check("async_pattern", pattern, '0);
    check("async_done",    done, 1'b0);
    repeat (2) tick();
    check("rst_step_ignored", state_reg, 2'b01);
    reset = 1'b1;
    command = 1'b0; countIn = 4'd9;
    tick();
    check("post_rst_state",   state_reg, 2'b01);
    check("post_rst_clamped", clamped, 1'b1);

    // illegal state recovery from DONE
    countIn = 4'd2;
    tick();
    command = 1'b1;
    repeat (4) tick();
    check("pre_force_state", state_reg, 2'b11);
    step = 1'b0;
    force dut.state_q = 2'b00;
    #1;
    check("forced_state", state_reg, 2'b00);
    release dut.state_q;
    step = 1'b1;
    tick();
    check("illegal_recover", state_reg, 2'b01);
    check("illegal_done",    done, 1'b0);
    command = 1'b0;
    tick();

    // randomized transactions
    for (int i = 0; i < 40; i++) begin
      run_txn($urandom_range(15), 1'($urandom), $urandom_range(100, 40), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
